// File: rtl/pmem_line_responder.sv
// pmem_line_responder
// Responder end of the 128-bit physical-memory line interface. Holds a
// line-granular backing store and serves one request at a time with a fixed
// LATENCY. The latency is counted from the first request cycle in IDLE to the
// pmem_resp cycle. It also flags protocol errors (sticky) and counts
// completed reads and writes (saturating).
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   pmem_address  byte address; line index is [LINE_ADDR_BITS+3:4]
//   pmem_read     line read request, held until pmem_resp
//   pmem_write    line write request, held until pmem_resp
//   pmem_wdata    write line, captured when the request is accepted
//   pmem_rdata    read line, non-zero only in the pmem_resp cycle
//   pmem_resp     one-cycle completion pulse
//   pmem_error    sticky protocol-error flag
//   read_count    completed reads, saturating
//   write_count   completed writes, saturating
//
// state | meaning
// IDLE  | waiting for pmem_read / pmem_write
// BUSY  | request latched, counting down the latency
// RESP  | pmem_resp high; read data presented or write committed
module pmem_line_responder #(
    parameter int LATENCY        = 10,
    parameter int LINE_ADDR_BITS = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  pmem_address,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         pmem_error,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
);

    localparam int DEPTH = 2 ** LINE_ADDR_BITS;
    // The counter is loaded in the accept edge, so two cycles of the total
    // latency are spent in IDLE (accept) and RESP itself.
    localparam logic [7:0] LOAD = 8'(LATENCY - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t                    r_state;
    logic [7:0]                r_count;
    logic [LINE_ADDR_BITS-1:0] r_index;
    logic                      r_is_write;
    logic [127:0]              r_wdata;
    logic [127:0]              r_rdata;
    logic                      r_resp;
    logic                      r_error;
    logic [15:0]               r_rd_cnt;
    logic [15:0]               r_wr_cnt;
    logic [127:0]              r_mem [DEPTH];

    logic [LINE_ADDR_BITS-1:0] w_index;
    logic                      w_req_held;
    logic                      w_unused_addr_bits;

    assign w_index            = pmem_address[LINE_ADDR_BITS+3:4];
    // Only the input of the accepted operation must stay high; a both-high
    // request was accepted as a write, so only pmem_write is watched.
    assign w_req_held         = r_is_write ? pmem_write : pmem_read;
    // Offset bits and bits above the index are intentionally ignored.
    assign w_unused_addr_bits = ^pmem_address;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= 8'd0;
            r_index    <= '0;
            r_is_write <= 1'b0;
            r_wdata    <= 128'h0;
            r_rdata    <= 128'h0;
            r_resp     <= 1'b0;
            r_error    <= 1'b0;
            r_rd_cnt   <= 16'h0;
            r_wr_cnt   <= 16'h0;
        end else begin
            r_resp  <= 1'b0;
            r_rdata <= 128'h0;
            case (r_state)
                S_IDLE: begin
                    if (pmem_read || pmem_write) begin
                        r_index    <= w_index;
                        r_is_write <= pmem_write;
                        r_wdata    <= pmem_wdata;
                        r_count    <= LOAD;
                        r_state    <= S_BUSY;
                        if (pmem_read && pmem_write) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (!w_req_held) begin
                        r_state <= S_IDLE;
                        r_error <= 1'b1;
                    end else if (r_count == 8'd0) begin
                        r_state <= S_RESP;
                        r_resp  <= 1'b1;
                        if (!r_is_write) begin
                            r_rdata <= r_mem[r_index];
                        end
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    if (r_is_write) begin
                        if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
                    end else begin
                        if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Backing store is never cleared; reset only blocks the pending commit.
    always_ff @(posedge clk) begin
        if (!reset && r_state == S_RESP && r_is_write) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    assign pmem_rdata  = r_rdata;
    assign pmem_resp   = r_resp;
    assign pmem_error  = r_error;
    assign read_count  = r_rd_cnt;
    assign write_count = r_wr_cnt;

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Responder end of the 128-bit physical-memory line interface that the cache datapaths drive (pmem_address, pmem_read, pmem_write, pmem_wdata, pmem_rdata, pmem_resp).
- Holds a line-granular backing store and serves one request at a time with a fixed, parameterized latency.
- Sits below the I/D caches (or a future arbiter) as the simulation/synthesis main-memory model.
- Also reports protocol errors and counts completed transactions for performance checks.

Parameters:
LATENCY, 10, cycles from the first request cycle in IDLE to the pmem_resp cycle; legal range 2..255.
LINE_ADDR_BITS, 12, number of line-index bits; the index is pmem_address[LINE_ADDR_BITS+3:4]; depth is 2**LINE_ADDR_BITS lines.

Ports:
clk  input  1  system clock, all state updates on its rising edge
reset  input  1  synchronous, active-high reset
pmem_address  input  16  byte address; bits [3:0] ignored (line aligned)
pmem_read  input  1  line read request, held high until pmem_resp
pmem_write  input  1  line write request, held high until pmem_resp
pmem_wdata  input  128  write line data, sampled when the request is accepted
pmem_rdata  output  128  read line data, valid only while pmem_resp=1
pmem_resp  output  1  one-cycle completion pulse
pmem_error  output  1  sticky protocol-error flag
read_count  output  16  completed reads, saturating at 16'hFFFF
write_count  output  16  completed writes, saturating at 16'hFFFF

Behaviour:
- Reset, synchronous with clk high:
  - State goes to IDLE; the counter, pmem_resp, pmem_error, read_count and write_count all clear to 0.
  - pmem_rdata goes to 128'h0.
  - Backing-store contents are not cleared.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If pmem_read or pmem_write is high at a rising edge, latch the line index, the operation and pmem_wdata, load the counter with LATENCY-2, and go to BUSY.
  - If both are high, perform the write, ignore the read, and set pmem_error.
- BUSY:
  - Decrement the counter each cycle. At 0, go to RESP.
  - If the latched request's input drops while in BUSY: abort, return to IDLE, commit nothing, set pmem_error.
  - Changes to pmem_address or pmem_wdata during BUSY are ignored; the values latched at acceptance are used.
- RESP:
  - pmem_resp=1 for exactly one cycle.
  - Read: pmem_rdata = mem[latched index] during this cycle.
  - Write: mem[latched index] <= latched wdata at the end of this cycle.
  - The matching count increments unless already 16'hFFFF. Next state is IDLE.
- Latency:
  - The request is first high in IDLE at cycle 0. pmem_resp is high in cycle LATENCY.
  - A request still high in the cycle after RESP is treated as a new request. Requesters must deassert on the edge that ends RESP.
- Outputs outside RESP: pmem_rdata holds 128'h0 and pmem_resp is 0.
- pmem_error is sticky; only reset clears it.
- Reset mid-operation: any in-flight write is discarded. The reset cycle itself never asserts pmem_resp.
- Line index wrap: address bits above LINE_ADDR_BITS+3 are ignored, so the address aliases modulo the depth.
- Read-after-write to the same line: the later read returns the new data.

Test Plan:
- Write then read, LATENCY=10:
  - Write pmem_address=16'h0120, wdata=128'hDEAD_BEEF_0011_2233_4455_6677_8899_AABB. pmem_resp is high exactly in cycle 10.
  - Then read 16'h012C. pmem_rdata equals the same line in the resp cycle, and 128'h0 otherwise. write_count=1, read_count=1.
- Latency sweep for LATENCY=2 and LATENCY=255: resp lands in cycle 2 and cycle 255 respectively, always one cycle wide.
- Abort:
  - Assert pmem_write to 16'h0040 with new data, then drop it in cycle 4. No resp occurs, pmem_error=1.
  - A following read of 16'h0040 returns the old contents.
- Simultaneous read and write to 16'h0200: the write commits, pmem_error=1, write_count increments, read_count is unchanged.
- Reset mid-operation: assert reset in cycle 5 of a write. Required after reset:
  - All outputs are 0 the next cycle.
  - The targeted line keeps its prior value.
  - A new request completes normally with latency LATENCY.
- Aliasing with LINE_ADDR_BITS=4: a write to 16'h0100 followed by a read of 16'h0000 returns the written data.
